// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch unit with a DEPTH-entry prefetch queue.
//   Owns the fetch PC, issues one word request per cycle to a synchronous
//   instruction memory, resolves unconditional B/BR at fetch time and buffers
//   fetched words (with their PCs) for Instruction Decode.
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   im_en, im_addr    request strobe / word-aligned byte address to IM
//   im_data           IM read data, valid the cycle after im_en
//   br_addr, br_value register index for BR and its combinational value
//   redirect(_pc)     flush queue and restart fetch at redirect_pc
//   id_valid/ready    head-of-queue handshake; id_instr/id_pc carry the head
//   pc_out            current fetch PC
//   count             queue occupancy
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [6:0]      B_OPC    = 7'b1100000,
  parameter logic [6:0]      BR_OPC   = 7'b1100010
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       im_en,
  output logic [XLEN-1:0]            im_addr,
  input  logic [31:0]                im_data,
  output logic [2:0]                 br_addr,
  input  logic [XLEN-1:0]            br_value,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_instr,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            pc_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          last_q, last_d;

  logic            deq, enq, take, credit, is_b, is_br;
  logic [CW:0]     occ;
  logic [XLEN-1:0] imm, tgt;

  always_comb begin
    is_b     = (im_data[31:25] == B_OPC);
    is_br    = (im_data[31:25] == BR_OPC);
    imm      = {{(XLEN-16){im_data[15]}}, im_data[15:0]};
    tgt      = ((is_br ? br_value : rpc_q) + imm) & ALIGN_MASK;

    id_valid = (count_q != '0);
    deq      = id_valid & id_ready;
    // A redirect never lets a request issue, so the only response that can be
    // stale is the one arriving in the redirect cycle itself; it is dropped
    // directly here rather than through a separate kill flag.
    take     = rv_q & (is_b | is_br);
    enq      = rv_q & ~redirect;

    // Entries already queued plus the one in flight must leave room.
    occ      = {1'b0, count_q} + (CW+1)'(rv_q) - (CW+1)'(deq);
    credit   = (occ < (CW+1)'(DEPTH));
    // Gated by reset so no request strobe is seen while reset is held.
    im_en    = credit & ~redirect & ~take & ~reset;

    fpc_d = fpc_q;
    if (redirect)   fpc_d = redirect_pc & ALIGN_MASK;
    else if (take)  fpc_d = tgt;
    else if (im_en) fpc_d = fpc_q + XLEN'(4);

    rv_d  = im_en;
    rpc_d = im_en ? fpc_q : rpc_q;

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[wptr_q] = '{instr: im_data, pc: rpc_q};
        wptr_d        = wptr_q + PW'(1);
      end
      if (deq) rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end

    // Shadow of the head so the ID outputs hold their last value when empty.
    last_d = id_valid ? mem_q[rptr_q] : last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      last_q  <= last_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    im_addr  = fpc_q;
    pc_out   = fpc_q;
    count    = count_q;
    br_addr  = rv_q ? im_data[24:22] : 3'b000;
    id_instr = id_valid ? mem_q[rptr_q].instr : last_q.instr;
    id_pc    = id_valid ? mem_q[rptr_q].pc    : last_q.pc;
  end

endmodule
